// File: rtl/max_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : max_scan_ctrl (with helper max_scan_addsub)
// Purpose  : Streams a frame of N-bit unsigned operands through one shared
//            subtract-based comparator and reports the frame maximum.
//            A start pulse arms the controller for len words, words are taken
//            one per cycle over valid/ready, and done pulses once the result
//            is final. The result is held until the next accepted start.
// Ports    : clk      - rising-edge clock
//            rst      - synchronous active-high reset
//            start    - arm a new frame (sampled only in IDLE)
//            len      - frame word count, sampled with start (saturated)
//            in_valid - in_data is valid
//            in_data  - N-bit unsigned operand
//            in_ready - controller accepts in_data this cycle (SCAN only)
//            busy     - high in SCAN and DONE
//            done     - one-cycle pulse, result valid from this cycle on
//            max_out  - frame maximum
//            idx_out  - 0-based position of the maximum (MAX_SCAN_INDEX_EN)
// Config   : `define MAX_SCAN_INDEX_EN to compile in idx_out, the index
//            register and the position counter.
// Revision : 1.0 - initial release
// ============================================================================

// N-bit add/subtract unit. In subtract mode it forms a + ~b + 1 over N+1
// bits, so result[N] is the borrow (set when a < b).
module max_scan_addsub #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N:0]   result
);

  logic [N:0] w_b_ext;

  always_comb begin
    w_b_ext = sub ? ~{1'b0, b} : {1'b0, b};
    result  = {1'b0, a} + w_b_ext + {{N{1'b0}}, sub};
  end

endmodule

module max_scan_ctrl #(
  parameter  int N       = 5,
  parameter  int LEN_MAX = 15,
  localparam int CW      = $clog2(LEN_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  max_out
`ifdef MAX_SCAN_INDEX_EN
  ,
  output logic [CW-1:0] idx_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LEN_MAX = CW'(LEN_MAX);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          got_first_q, got_first_d;
  logic [N-1:0]  max_q, max_d;
`ifdef MAX_SCAN_INDEX_EN
  logic [CW-1:0] pos_q, pos_d;
  logic [CW-1:0] idx_q, idx_d;
`endif

  logic [CW-1:0] w_len_sat;
  logic          w_accept;
  logic [N:0]    w_diff;
  logic          w_greater;

  // Shared comparator: in_data - max_q, one instance for the whole frame.
  max_scan_addsub #(
    .N (N)
  ) u_cmp (
    .a      (in_data),
    .b      (max_q),
    .sub    (1'b1),
    .result (w_diff)
  );

  // No borrow and a non-zero difference means strictly greater; ties keep
  // the earlier word.
  assign w_greater = ~w_diff[N] & (|w_diff[N-1:0]);
  assign w_len_sat = (len > C_LEN_MAX) ? C_LEN_MAX : len;
  assign w_accept  = in_valid && (state_q == ST_SCAN);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    got_first_d = got_first_q;
    max_d       = max_q;
`ifdef MAX_SCAN_INDEX_EN
    pos_d       = pos_q;
    idx_d       = idx_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          max_d       = '0;
          got_first_d = 1'b0;
`ifdef MAX_SCAN_INDEX_EN
          pos_d       = '0;
          idx_d       = '0;
`endif
          if (w_len_sat != '0) begin
            rem_d   = w_len_sat;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SCAN: begin
        if (w_accept) begin
          // The first word loads unconditionally, whatever the comparator says.
          if (!got_first_q || w_greater) begin
            max_d = in_data;
`ifdef MAX_SCAN_INDEX_EN
            idx_d = pos_q;
`endif
          end
          got_first_d = 1'b1;
          rem_d       = rem_q - C_ONE;
`ifdef MAX_SCAN_INDEX_EN
          pos_d       = pos_q + C_ONE;
`endif
          if (rem_q == C_ONE) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      got_first_q <= 1'b0;
      max_q       <= '0;
`ifdef MAX_SCAN_INDEX_EN
      pos_q       <= '0;
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      got_first_q <= got_first_d;
      max_q       <= max_d;
`ifdef MAX_SCAN_INDEX_EN
      pos_q       <= pos_d;
      idx_q       <= idx_d;
`endif
    end
  end

  // Moore outputs decoded from the state register.
  assign in_ready = (state_q == ST_SCAN);
  assign busy     = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign max_out  = max_q;
`ifdef MAX_SCAN_INDEX_EN
  assign idx_out  = idx_q;
`endif

endmodule

`default_nettype wire
